// File: rtl/k_and_s_pkg.sv
// Shared K&S processor types: the decoded instruction set seen by control_unit and data_path.
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_BRANCH,
        I_BZERO,
        I_BNZERO,
        I_BNEG,
        I_BNNEG,
        I_HALT
    } decoded_instruction_type;

endpackage

// File: rtl/control_unit.sv
// K&S processor sequencer: multi-cycle Moore FSM driving all data_path enables/selects.
// Outputs are registered copies of a decode of the next state, so they track the state register exactly.
module control_unit #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  k_and_s_pkg::decoded_instruction_type decoded_instruction,
    input  logic                                 zero_op,
    input  logic                                 neg_op,
    output logic                                 branch,
    output logic                                 pc_enable,
    output logic                                 ir_enable,
    output logic                                 addr_sel,
    output logic                                 c_sel,
    output logic [1:0]                           operation,
    output logic                                 write_reg_enable,
    output logic                                 flags_reg_enable,
    output logic                                 ram_write_enable,
    output logic                                 halt
);

    import k_and_s_pkg::*;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_LOAD,
        S_STORE,
        S_ALU,
        S_MOVE,
        S_BRANCH,
        S_HALT
    } state_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [1:0] op, op_n;
    logic       last;

    logic       branch_n, pc_enable_n, ir_enable_n, addr_sel_n, c_sel_n;
    logic [1:0] operation_n;
    logic       write_reg_enable_n, flags_reg_enable_n, ram_write_enable_n, halt_n;
    logic       last_n;

    assign last = (cnt == WAIT_LAST);

    // Next-state / wait counter / captured ALU op
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = op;
        case (state)
            S_RESET: begin
                state_n = S_FETCH;
                cnt_n   = '0;
            end
            S_FETCH: begin
                if (last) state_n = S_DECODE;
                else      cnt_n   = cnt + 4'd1;
            end
            S_DECODE: begin
                state_n = S_FETCH;
                cnt_n   = '0;
                case (decoded_instruction)
                    I_NOP:    state_n = S_FETCH;
                    I_LOAD:   state_n = S_LOAD;
                    I_STORE:  state_n = S_STORE;
                    I_MOVE: begin
                        state_n = S_MOVE;
                        op_n    = OP_OR;
                    end
                    I_ADD: begin
                        state_n = S_ALU;
                        op_n    = OP_ADD;
                    end
                    I_SUB: begin
                        state_n = S_ALU;
                        op_n    = OP_SUB;
                    end
                    I_AND: begin
                        state_n = S_ALU;
                        op_n    = OP_AND;
                    end
                    I_OR: begin
                        state_n = S_ALU;
                        op_n    = OP_OR;
                    end
                    I_BRANCH: state_n = S_BRANCH;
                    I_BZERO:  state_n = zero_op  ? S_BRANCH : S_FETCH;
                    I_BNZERO: state_n = !zero_op ? S_BRANCH : S_FETCH;
                    I_BNEG:   state_n = neg_op   ? S_BRANCH : S_FETCH;
                    I_BNNEG:  state_n = !neg_op  ? S_BRANCH : S_FETCH;
                    I_HALT:   state_n = S_HALT;
                    default:  state_n = S_FETCH;
                endcase
            end
            S_LOAD, S_STORE: begin
                if (last) begin
                    state_n = S_FETCH;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            S_ALU, S_MOVE, S_BRANCH: begin
                state_n = S_FETCH;
                cnt_n   = '0;
            end
            S_HALT:  state_n = S_HALT;
            default: begin
                state_n = S_RESET;
                cnt_n   = '0;
            end
        endcase
    end

    assign last_n = (cnt_n == WAIT_LAST);

    // Moore output decode of the upcoming state, registered below
    always_comb begin
        branch_n           = 1'b0;
        pc_enable_n        = 1'b0;
        ir_enable_n        = 1'b0;
        addr_sel_n         = 1'b0;
        c_sel_n            = 1'b0;
        operation_n        = OP_OR;
        write_reg_enable_n = 1'b0;
        flags_reg_enable_n = 1'b0;
        ram_write_enable_n = 1'b0;
        halt_n             = 1'b0;
        case (state_n)
            S_FETCH: begin
                addr_sel_n  = 1'b1;
                ir_enable_n = last_n;
            end
            S_DECODE: pc_enable_n = 1'b1;
            S_LOAD: begin
                c_sel_n            = 1'b1;
                write_reg_enable_n = last_n;
            end
            S_STORE: ram_write_enable_n = last_n;
            S_ALU: begin
                operation_n        = op_n;
                write_reg_enable_n = 1'b1;
                flags_reg_enable_n = 1'b1;
            end
            S_MOVE: write_reg_enable_n = 1'b1;
            S_BRANCH: begin
                branch_n    = 1'b1;
                pc_enable_n = 1'b1;
            end
            S_HALT:  halt_n = 1'b1;
            default: halt_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_RESET;
            cnt              <= '0;
            op               <= OP_OR;
            branch           <= 1'b0;
            pc_enable        <= 1'b0;
            ir_enable        <= 1'b0;
            addr_sel         <= 1'b0;
            c_sel            <= 1'b0;
            operation        <= OP_OR;
            write_reg_enable <= 1'b0;
            flags_reg_enable <= 1'b0;
            ram_write_enable <= 1'b0;
            halt             <= 1'b0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            op               <= op_n;
            branch           <= branch_n;
            pc_enable        <= pc_enable_n;
            ir_enable        <= ir_enable_n;
            addr_sel         <= addr_sel_n;
            c_sel            <= c_sel_n;
            operation        <= operation_n;
            write_reg_enable <= write_reg_enable_n;
            flags_reg_enable <= flags_reg_enable_n;
            ram_write_enable <= ram_write_enable_n;
            halt             <= halt_n;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: two instances (MEM_WAIT 0 and 2) driven by directed sequences.
module tb_control_unit;

    import k_and_s_pkg::*;

    // Output vector: {branch,pc_enable,ir_enable,addr_sel,c_sel,operation[1:0],write_reg,flags_reg,ram_we,halt}
    localparam logic [10:0] V_ZERO    = 11'h000;
    localparam logic [10:0] V_FETCH   = 11'h080;
    localparam logic [10:0] V_FETCH_L = 11'h180;
    localparam logic [10:0] V_DECODE  = 11'h200;
    localparam logic [10:0] V_ADD     = 11'h01C;
    localparam logic [10:0] V_SUB     = 11'h02C;
    localparam logic [10:0] V_AND     = 11'h03C;
    localparam logic [10:0] V_OR      = 11'h00C;
    localparam logic [10:0] V_MOVE    = 11'h008;
    localparam logic [10:0] V_LOAD    = 11'h040;
    localparam logic [10:0] V_LOAD_L  = 11'h048;
    localparam logic [10:0] V_STORE   = 11'h000;
    localparam logic [10:0] V_STORE_L = 11'h002;
    localparam logic [10:0] V_BRANCH  = 11'h600;
    localparam logic [10:0] V_HALT    = 11'h001;

    typedef struct {
        int unsigned cyc;
        bit          which;
        logic [10:0] vec;
        string       name;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic                    rst0, rst2, zero0, neg0, zero2, neg2;
    decoded_instruction_type di0, di2;
    logic       br0, pc0, ir0, as0, cs0, wr0, fl0, rw0, h0;
    logic       br2, pc2, ir2, as2, cs2, wr2, fl2, rw2, h2;
    logic [1:0] op0, op2;
    logic [10:0] out0, out2;

    assign out0 = {br0, pc0, ir0, as0, cs0, op0, wr0, fl0, rw0, h0};
    assign out2 = {br2, pc2, ir2, as2, cs2, op2, wr2, fl2, rw2, h2};

    control_unit #(.MEM_WAIT(0)) dut0 (
        .clk(clk), .rst_n(rst0), .decoded_instruction(di0), .zero_op(zero0), .neg_op(neg0),
        .branch(br0), .pc_enable(pc0), .ir_enable(ir0), .addr_sel(as0), .c_sel(cs0),
        .operation(op0), .write_reg_enable(wr0), .flags_reg_enable(fl0),
        .ram_write_enable(rw0), .halt(h0)
    );

    control_unit #(.MEM_WAIT(2)) dut2 (
        .clk(clk), .rst_n(rst2), .decoded_instruction(di2), .zero_op(zero2), .neg_op(neg2),
        .branch(br2), .pc_enable(pc2), .ir_enable(ir2), .addr_sel(as2), .c_sel(cs2),
        .operation(op2), .write_reg_enable(wr2), .flags_reg_enable(fl2),
        .ram_write_enable(rw2), .halt(h2)
    );

    // Queue the expected outputs of the next cycle, then advance past that edge
    task automatic step(input bit which, input logic [10:0] vec, input string name);
        exp_t e;
        e.cyc   = cyc + 1;
        e.which = which;
        e.vec   = vec;
        e.name  = name;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [10:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e   = q.pop_front();
                act = e.which ? out2 : out0;
                checks++;
                if (e.cyc != cyc || act !== e.vec) begin
                    errors++;
                    $display("FAIL %s (dut%0d cyc %0d): got %h expected %h at cyc %0d",
                             e.name, e.which ? 2 : 0, cyc, act, e.vec, e.cyc);
                end
            end
        end
    end

    initial begin : stimulus
        rst0 = 1'b0; rst2 = 1'b0;
        di0 = I_ADD; di2 = I_NOP;
        zero0 = 1'b0; neg0 = 1'b0; zero2 = 1'b0; neg2 = 1'b0;

        // Reset and ADD round trip
        step(0, V_ZERO, "reset");
        rst0 = 1'b1;
        step(0, V_FETCH_L, "fetch_after_reset");
        step(0, V_DECODE,  "add_decode");
        step(0, V_ADD,     "add_alu");
        step(0, V_FETCH_L, "add_back_fetch");
        step(0, V_DECODE,  "add2_decode");
        step(0, V_ADD,     "add2_alu");
        rst0 = 1'b0;
        step(0, V_ZERO, "rst_from_alu");
        step(0, V_ZERO, "rst_hold");
        rst0 = 1'b1;
        step(0, V_FETCH_L, "rst_release");

        // Op captured at DECODE; later instruction changes must not leak
        di0 = I_SUB;
        step(0, V_DECODE, "sub_decode");
        step(0, V_SUB,    "sub_alu");
        di0 = I_AND;
        step(0, V_FETCH_L, "sub_back");
        step(0, V_DECODE,  "and_decode");
        step(0, V_AND,     "and_alu");
        di0 = I_OR;
        step(0, V_FETCH_L, "and_back");
        step(0, V_DECODE,  "or_decode");
        step(0, V_OR,      "or_alu");
        di0 = I_MOVE;
        step(0, V_FETCH_L, "or_back");
        step(0, V_DECODE,  "move_decode");
        step(0, V_MOVE,    "move");
        di0 = I_ADD;
        step(0, V_FETCH_L, "move_back");

        // Conditional branches
        di0 = I_BZERO; zero0 = 1'b1;
        step(0, V_DECODE,  "bzero_t_decode");
        step(0, V_BRANCH,  "bzero_taken");
        step(0, V_FETCH_L, "bzero_t_back");
        zero0 = 1'b0;
        step(0, V_DECODE,  "bzero_nt_decode");
        step(0, V_FETCH_L, "bzero_not_taken");
        di0 = I_BNZERO;
        step(0, V_DECODE,  "bnzero_decode");
        step(0, V_BRANCH,  "bnzero_taken");
        step(0, V_FETCH_L, "bnzero_back");
        di0 = I_BNNEG; neg0 = 1'b0;
        step(0, V_DECODE,  "bnneg_decode");
        step(0, V_BRANCH,  "bnneg_taken");
        step(0, V_FETCH_L, "bnneg_back");
        di0 = I_BNEG;
        step(0, V_DECODE,  "bneg_decode");
        step(0, V_FETCH_L, "bneg_not_taken");
        neg0 = 1'b1;
        step(0, V_DECODE,  "bneg2_decode");
        step(0, V_BRANCH,  "bneg_taken");
        step(0, V_FETCH_L, "bneg_back");
        di0 = I_BRANCH;
        step(0, V_DECODE,  "branch_decode");
        step(0, V_BRANCH,  "branch_uncond");
        step(0, V_FETCH_L, "branch_back");

        // Memory ops, NOP and illegal encoding at MEM_WAIT=0
        di0 = I_STORE;
        step(0, V_DECODE,  "store_decode");
        step(0, V_STORE_L, "store_strobe");
        step(0, V_FETCH_L, "store_back");
        di0 = I_LOAD;
        step(0, V_DECODE,  "load_decode");
        step(0, V_LOAD_L,  "load_strobe");
        step(0, V_FETCH_L, "load_back");
        di0 = I_NOP;
        step(0, V_DECODE,  "nop_decode");
        step(0, V_FETCH_L, "nop_back");
        di0 = decoded_instruction_type'(4'hF);
        step(0, V_DECODE,  "illegal_decode");
        step(0, V_FETCH_L, "illegal_back");

        // HALT is sticky until reset
        di0 = I_HALT;
        step(0, V_DECODE, "halt_decode");
        for (int i = 0; i < 20; i++) begin
            step(0, V_HALT, "halt_hold");
            di0   = decoded_instruction_type'(4'($urandom_range(0, 15)));
            zero0 = 1'($urandom_range(0, 1));
            neg0  = 1'($urandom_range(0, 1));
        end
        rst0 = 1'b0;
        step(0, V_ZERO, "halt_reset");
        rst0 = 1'b1;
        step(0, V_FETCH_L, "halt_release");

        // MEM_WAIT=2: LOAD then STORE
        di2 = I_LOAD;
        step(1, V_ZERO, "w2_reset");
        rst2 = 1'b1;
        step(1, V_FETCH,   "w2_fetch0");
        step(1, V_FETCH,   "w2_fetch1");
        step(1, V_FETCH_L, "w2_fetch2");
        step(1, V_DECODE,  "w2_load_decode");
        step(1, V_LOAD,    "w2_load0");
        step(1, V_LOAD,    "w2_load1");
        step(1, V_LOAD_L,  "w2_load2");
        di2 = I_STORE;
        step(1, V_FETCH,   "w2_fetch0b");
        step(1, V_FETCH,   "w2_fetch1b");
        step(1, V_FETCH_L, "w2_fetch2b");
        step(1, V_DECODE,  "w2_store_decode");
        step(1, V_STORE,   "w2_store0");
        step(1, V_STORE,   "w2_store1");
        step(1, V_STORE_L, "w2_store2");
        step(1, V_FETCH,   "w2_store_back");

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
